// File: rtl/wb_ddr_line_buffer_ctrl_pkg.sv
// Shared types and geometry for the Wishbone line-buffer controller.
// LINE_OFS and TAG_W describe the default 8-word line.
package wb_ddr_line_buffer_ctrl_pkg;

   localparam int ADDR_WIDTH_DEF = 3;
   localparam int LINE_OFS       = ADDR_WIDTH_DEF + 2;
   localparam int TAG_W          = 32 - LINE_OFS;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_ACK = 3'd1,
      WR_ACK = 3'd2,
      WB     = 3'd3,
      FILL   = 3'd4
   } state_t;

endpackage

// File: rtl/wb_ddr_line_buffer_ctrl.sv
// Wishbone classic slave owning port A of the line buffer: one tagged line,
// hits served from the buffer, misses resolved via DDR writeback/fill requests.
//
// state  | meaning
// IDLE   | waiting for cyc&stb; decodes hit/miss, drives write hit enables
// RD_ACK | ack a read hit; buffer read data is valid this cycle
// WR_ACK | ack a write hit
// WB     | writeback of the dirty resident line requested from DDR engine
// FILL   | fill of the requested line requested from DDR engine
module wb_ddr_line_buffer_ctrl
   import wb_ddr_line_buffer_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic [ADDR_WIDTH-1:0] buf_addr_o,
   output logic [3:0]            buf_we_o,
   output logic [31:0]           buf_dat_o,
   input  logic [31:0]           buf_dat_i,
   output logic                  line_req_o,
   output logic                  line_wb_o,
   output logic [31:0]           line_adr_o,
   input  logic                  line_done_i
);

   // Package geometry is for the default line; shift it when overridden.
   localparam int LOFS = LINE_OFS + ADDR_WIDTH - ADDR_WIDTH_DEF;
   localparam int TW   = TAG_W - (ADDR_WIDTH - ADDR_WIDTH_DEF);

   state_t          state;
   logic [TW-1:0]   tag;
   logic [TW-1:0]   fill_tag;
   logic [TW-1:0]   adr_tag;
   logic            valid;
   logic            dirty;
   logic            req;
   logic            hit;
   logic            unused_adr;

   assign adr_tag    = wb_adr_i[31:LOFS];
   assign req        = wb_cyc_i & wb_stb_i;
   assign hit        = valid && (tag == adr_tag);
   assign unused_adr = ^wb_adr_i[1:0];

   assign buf_addr_o = wb_adr_i[ADDR_WIDTH+1:2];
   assign buf_dat_o  = wb_dat_i;
   assign wb_dat_o   = buf_dat_i;

   // Byte enables go out in the same cycle the write hit is decoded.
   assign buf_we_o = (!wb_rst_i && state == IDLE && req && hit && wb_we_i) ? wb_sel_i : 4'b0000;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         valid      <= 1'b0;
         dirty      <= 1'b0;
         tag        <= '0;
         fill_tag   <= '0;
         wb_ack_o   <= 1'b0;
         line_req_o <= 1'b0;
         line_wb_o  <= 1'b0;
         line_adr_o <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     wb_ack_o <= 1'b1;
                     if (wb_we_i) begin
                        if (wb_sel_i != 4'b0000) dirty <= 1'b1;
                        state <= WR_ACK;
                     end else begin
                        state <= RD_ACK;
                     end
                  end else begin
                     fill_tag   <= adr_tag;
                     line_req_o <= 1'b1;
                     if (valid && dirty) begin
                        line_wb_o  <= 1'b1;
                        line_adr_o <= {tag, {LOFS{1'b0}}};
                        state      <= WB;
                     end else begin
                        line_wb_o  <= 1'b0;
                        line_adr_o <= {adr_tag, {LOFS{1'b0}}};
                        state      <= FILL;
                     end
                  end
               end
            end
            RD_ACK, WR_ACK: state <= IDLE;
            WB: begin
               // Request stays up; only its kind and address change for the fill.
               if (line_done_i) begin
                  dirty      <= 1'b0;
                  line_wb_o  <= 1'b0;
                  line_adr_o <= {fill_tag, {LOFS{1'b0}}};
                  state      <= FILL;
               end
            end
            FILL: begin
               if (line_done_i) begin
                  tag        <= fill_tag;
                  valid      <= 1'b1;
                  dirty      <= 1'b0;
                  line_req_o <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
